// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and SPI mode constants for the SPI receive master
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic CPOL_LOW   = 1'b0;
    localparam logic CPOL_HIGH  = 1'b1;
    localparam logic CPHA_LEAD  = 1'b0;
    localparam logic CPHA_TRAIL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input bit
module sync_2ff (
    input  logic clk,
    input  logic rst_a_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_rx_master.sv
// rtl/spi_rx_master.sv - SPI receive-only master; define SPI_RX_AUTO_EN to add auto_run for back-to-back frames
module spi_rx_master
    import spi_pkg::*;
#(
    parameter int   DATA_W   = 16,
    parameter int   HALF_DIV = 4,
    parameter int   CS_GAP   = 2,
    parameter logic CPOL     = CPOL_HIGH,
    parameter logic CPHA     = CPHA_LEAD
) (
    input  logic              clk,
    input  logic              rst_a_n,
    input  logic              start,
`ifdef SPI_RX_AUTO_EN
    input  logic              auto_run,
`endif
    input  logic              from_device,
    output logic              sclk,
    output logic              cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);
    localparam int EDGES  = 2 * DATA_W;
    localparam int DIV_W  = $clog2(HALF_DIV);
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam int GAP_W  = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);

    state_t            state, next_state;
    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              miso_sync;
    logic              div_tick, gap_done, go_auto, active;
    logic              edge_now, sample_now, done_now, sclk_next, cs_n_next;

    sync_2ff u_sync (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .d       (from_device),
        .q       (miso_sync)
    );

`ifdef SPI_RX_AUTO_EN
    assign go_auto = auto_run;
`else
    assign go_auto = 1'b0;
`endif

    assign div_tick = (div_cnt == DIV_LAST);
    assign gap_done = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start)    next_state = ST_LEAD;
            ST_LEAD:  if (div_tick) next_state = ST_XFER;
            ST_XFER:  if (div_tick && edge_cnt == EDGE_LAST) next_state = ST_TRAIL;
            ST_TRAIL: if (div_tick) next_state = ST_GAP;
            ST_GAP:   if (gap_done) next_state = go_auto ? ST_LEAD : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Edges open each XFER half-period: the LEAD tick makes edge 0, the final XFER tick makes none.
    always_comb begin
        active   = (state == ST_LEAD) || (state == ST_XFER) || (state == ST_TRAIL);
        edge_now = 1'b0;
        if (div_tick && state == ST_LEAD)
            edge_now = 1'b1;
        else if (div_tick && state == ST_XFER && edge_cnt != EDGE_LAST)
            edge_now = 1'b1;
        sample_now = edge_now && (edge_cnt[0] == CPHA);
        done_now   = (state == ST_TRAIL) && div_tick;
        cs_n_next  = !((next_state == ST_LEAD) || (next_state == ST_XFER) ||
                       (next_state == ST_TRAIL));
        if (next_state == ST_XFER) sclk_next = edge_now ? ~sclk : sclk;
        else                       sclk_next = CPOL;
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            div_cnt   <= '0;
            edge_cnt  <= '0;
            gap_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            sclk      <= CPOL;
            cs_n      <= 1'b1;
        end else begin
            div_cnt <= (active && !div_tick) ? div_cnt + 1'b1 : '0;
            if (state == ST_IDLE || state == ST_GAP) edge_cnt <= '0;
            else if (edge_now)                       edge_cnt <= edge_cnt + 1'b1;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (sample_now) shift_reg <= {shift_reg[DATA_W-2:0], miso_sync};
            if (done_now)   rx_data   <= shift_reg;
            rx_valid <= done_now;
            sclk     <= sclk_next;
            cs_n     <= cs_n_next;
        end
    end

endmodule

// File: doc/spi_rx_master.md
SPI_RX_MASTER -- requirements
Module: spi_rx_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per frame (range 2..32).
REQ-002 SHALL have parameter HALF_DIV, default 4, clk cycles per sclk half-period (minimum 3).
REQ-003 SHALL have parameter CS_GAP, default 2, clk cycles cs_n held high between frames (minimum 1).
REQ-004 SHALL have parameter CPOL, default 1, sclk idle level.
REQ-005 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port rst_a_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  request one frame, sampled only in IDLE.
REQ-009 SHALL have port from_device  in  1  asynchronous serial data from the slave (MISO).
REQ-010 SHALL have port sclk  out  1  registered serial clock.
REQ-011 SHALL have port cs_n  out  1  registered active-low chip select.
REQ-012 SHALL have port rx_data  out  DATA_W  last completed frame, MSB first.
REQ-013 SHALL have port rx_valid  out  1  one-cycle pulse, frame complete.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-015 SHALL pass from_device through a 2-flop synchronizer before any use.
REQ-016 SHALL implement states IDLE, LEAD, XFER, TRAIL, GAP.
REQ-017 SHALL move IDLE->LEAD on start=1; cs_n falls on the next cycle.
REQ-018 SHALL hold LEAD for HALF_DIV cycles (cs_n low, sclk=CPOL), then enter XFER.
REQ-019 SHALL, in XFER, toggle sclk every HALF_DIV cycles, producing exactly 2*DATA_W edges, then enter TRAIL.
REQ-020 SHALL shift the synchronized bit into a DATA_W shift register on the cycle each sample edge (per CPHA) is generated.
REQ-021 SHALL hold TRAIL for HALF_DIV cycles with sclk=CPOL, then raise cs_n, load rx_data, pulse rx_valid in that same cycle, and enter GAP.
REQ-022 SHALL give a cs_n low duration of exactly (2*DATA_W+2)*HALF_DIV cycles.
REQ-023 SHALL hold GAP for CS_GAP cycles, then return to IDLE.
REQ-024 SHALL ignore start outside IDLE, with no queuing; start asserted during the last GAP cycle is dropped.
REQ-025 SHALL keep rx_data stable between rx_valid pulses.
REQ-026 SHALL size the divider and bit counters with $clog2 of their maximum counts, with no wrap inside a frame.

Reset
REQ-027 SHALL, on rst_a_n low, immediately set state=IDLE, cs_n=1, sclk=CPOL, rx_valid=0, busy=0, rx_data=0, counters=0, shift register=0, synchronizer=0.
REQ-028 SHALL abort a frame on reset mid-frame, with no rx_valid for the aborted frame.
REQ-029 SHALL release reset without a glitch on cs_n or sclk.

Configuration
REQ-030 SHALL, with macro SPI_RX_AUTO_EN defined, add input port auto_run; when auto_run=1 at the end of GAP, go GAP->LEAD directly without start.
REQ-031 SHALL, without SPI_RX_AUTO_EN, omit auto_run and always go GAP->IDLE.

Structure
REQ-032 SHALL take the state enum (3-bit encoding) and the CPOL/CPHA mode constants from shared package spi_pkg.
REQ-033 SHALL instantiate sub-module sync_2ff for REQ-015; all other logic is flat.

Verification
REQ-034 SHALL test: DATA_W=16, HALF_DIV=4, CPOL=1, CPHA=0, slave model drives 0xA5C3 -> rx_data=0xA5C3, one rx_valid pulse, cs_n low 136 cycles, 32 sclk edges.
REQ-035 SHALL test: CPOL=0, CPHA=1, DATA_W=8, slave drives 0x3C -> rx_data=0x3C, sclk idles low before and after the frame.
REQ-036 SHALL test: start pulsed every cycle during a frame -> exactly one frame, busy high throughout, next frame only after GAP+IDLE.
REQ-037 SHALL test: rst_a_n low at edge 10 of a frame -> cs_n=1 and sclk=CPOL in the same cycle, no rx_valid, rx_data=0.
REQ-038 SHALL test: with SPI_RX_AUTO_EN and auto_run=1, CS_GAP=2 -> back-to-back frames with cs_n high for exactly 2 cycles, rx_valid once per frame.
REQ-039 SHALL test: from_device held 1 -> rx_data=all ones (0xFFFF for DATA_W=16); held 0 -> 0x0000 with rx_valid still pulsing.
